// File: rtl/shift_pkg.sv
// Shared definitions for the multicycle shifter: shift mode codes and FSM states.
package shift_pkg;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One shifter step: shifts acc by k (0..STEP) positions in the selected mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] res
);

  // Mode select; a left shift by WIDTH yields zero, so ROTR by k=0 returns acc.
  always_comb begin
    res = acc;
    case (mode)
      SH_SLL:  res = acc << k;
      SH_SRL:  res = acc >> k;
      SH_SRA:  res = WIDTH'($signed(acc) >>> k);
      SH_ROTR: res = (acc >> k) | (acc << (WIDTH - int'(k)));
      default: res = acc;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multicycle SLL/SRL/SRA/ROTR shifter moving at most STEP bits per cycle,
// with a start/ready handshake and a one-cycle done pulse.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         src,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result
);

  localparam int SHW = $clog2(WIDTH);
  localparam int KW  = $clog2(STEP + 1);
  localparam logic [SHW:0]  STEP_W = (SHW + 1)'(STEP);
  localparam logic [KW-1:0] STEP_K = KW'(STEP);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] result_r;
  logic [SHW:0]     rem_r;
  logic [SHW:0]     rem_next_s;
  logic [KW-1:0]    k_s;
  logic [1:0]       mode_r;

  // rem keeps one spare bit so the STEP-sized chunk never wraps it
  assign k_s        = (rem_r < STEP_W) ? rem_r[KW-1:0] : STEP_K;
  assign rem_next_s = rem_r - (SHW + 1)'(k_s);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc  (acc_r),
    .k    (k_s),
    .mode (mode_r),
    .res  (step_s)
  );

  assign ready  = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign busy   = (state_r == ST_SHIFT);
  assign done   = (state_r == ST_DONE);
  assign result = result_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE accepts a new request directly.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (shamt == {SHW{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_next_s == {(SHW + 1){1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture, per-cycle shifting, and result load as done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {WIDTH{1'b0}};
      rem_r    <= {(SHW + 1){1'b0}};
      mode_r   <= SH_SLL;
      result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc_r  <= src;
            rem_r  <= {1'b0, shamt};
            mode_r <= mode;
            if (shamt == {SHW{1'b0}}) begin
              result_r <= src;
            end
          end
        end
        ST_SHIFT: begin
          acc_r <= step_s;
          rem_r <= rem_next_s;
          if (rem_next_s == {(SHW + 1){1'b0}}) begin
            result_r <= step_s;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench: two shifter instances (STEP=1 and STEP=8) against a
// whole-shift reference model, plus directed literal cases.
module tb_iter_shifter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        start_v;
  logic [1:0][1:0]   mode_v;
  logic [1:0][W-1:0] src_v;
  logic [1:0][4:0]   shamt_v;
  logic [1:0]        ready_v;
  logic [1:0]        busy_v;
  logic [1:0]        done_v;
  logic [1:0][W-1:0] result_v;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    iter_shifter #(
      .WIDTH (W),
      .STEP  ((g == 0) ? 1 : 8)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_v[g]),
      .mode   (mode_v[g]),
      .src    (src_v[g]),
      .shamt  (shamt_v[g]),
      .ready  (ready_v[g]),
      .busy   (busy_v[g]),
      .done   (done_v[g]),
      .result (result_v[g])
    );
  end

  function automatic int step_of(int i);
    return (i == 0) ? 1 : 8;
  endfunction

  function automatic int nsteps(int sh, int st);
    return (sh + st - 1) / st;
  endfunction

  // Whole shift in one go, straight from the mode definitions.
  function automatic logic [W-1:0] ref_shift(logic [1:0] m, logic [W-1:0] s, int sh);
    case (m)
      2'b00:   return s << sh;
      2'b01:   return s >> sh;
      2'b10:   return $signed(s) >>> sh;
      2'b11:   return (sh == 0) ? s : ((s >> sh) | (s << (W - sh)));
      default: return '0;
    endcase
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: remaining busy cycles, pending and visible result.
  int             m_rem[2];
  logic           m_done[2];
  logic [W-1:0]   m_result[2];
  logic [W-1:0]   m_pend[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_rem[i]    <= 0;
        m_done[i]   <= 1'b0;
        m_result[i] <= '0;
        m_pend[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_rem[i] == 0 && start_v[i]) begin
          m_rem[i]  <= nsteps(int'(shamt_v[i]), step_of(i));
          m_pend[i] <= ref_shift(mode_v[i], src_v[i], int'(shamt_v[i]));
          m_done[i] <= (shamt_v[i] == 5'd0);
          if (shamt_v[i] == 5'd0) m_result[i] <= src_v[i];
        end else if (m_rem[i] != 0) begin
          m_rem[i]  <= m_rem[i] - 1;
          m_done[i] <= (m_rem[i] == 1);
          if (m_rem[i] == 1) m_result[i] <= m_pend[i];
        end else begin
          m_done[i] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready%0d", i), W'(ready_v[i]), W'(m_rem[i] == 0));
        chk($sformatf("busy%0d", i), W'(busy_v[i]), W'(m_rem[i] != 0));
        chk($sformatf("done%0d", i), W'(done_v[i]), W'(m_done[i]));
        chk($sformatf("result%0d", i), result_v[i], m_result[i]);
      end
    end
  end

  // One operation on instance i; inputs scrambled after accept.
  task automatic run_op(int i, logic [1:0] m, logic [W-1:0] s, logic [4:0] sh,
                        logic [W-1:0] exp_r, int exp_lat, int poke, bit b2b);
    int n;
    int busy_n;
    bit got;
    if (!b2b) @(negedge clk);
    start_v[i] = 1'b1; mode_v[i] = m; src_v[i] = s; shamt_v[i] = sh;
    @(posedge clk);
    n = 0; busy_n = 0; got = 1'b0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      start_v[i]  = (n == poke);
      mode_v[i]   = 2'($urandom_range(0, 3));
      src_v[i]    = $urandom;
      shamt_v[i]  = 5'($urandom_range(0, 31));
      if (b2b && n == 1) chk($sformatf("b2b_busy%0d", i), W'(busy_v[i]), W'(sh != 5'd0));
      if (busy_v[i]) busy_n++;
      if (done_v[i]) got = 1'b1;
    end
    start_v[i] = 1'b0;
    chk($sformatf("lat%0d_%h", i, s), W'(n), W'(exp_lat));
    chk($sformatf("busycyc%0d_%h", i, s), W'(busy_n), W'(exp_lat - 1));
    chk($sformatf("res%0d_%h", i, s), result_v[i], exp_r);
  endtask

  initial begin
    int dn;
    rst_n = 1'b0;
    start_v = '0; mode_v = '0; src_v = '0; shamt_v = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), W'(ready_v[i]), W'(1));
      chk($sformatf("rst_busy%0d", i), W'(busy_v[i]), W'(0));
      chk($sformatf("rst_done%0d", i), W'(done_v[i]), W'(0));
      chk($sformatf("rst_result%0d", i), result_v[i], 32'h0000_0000);
    end
    rst_n = 1'b1;

    chk("model_sra", ref_shift(2'b10, 32'h8000_00F0, 4), 32'hF800_000F);
    chk("model_srl", ref_shift(2'b01, 32'h8000_00F0, 4), 32'h0800_000F);
    chk("model_rotr", ref_shift(2'b11, 32'hDEAD_BEEF, 8), 32'hEFDE_ADBE);

    run_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 0, 1'b0);
    run_op(0, 2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F, 5,  0, 1'b0);
    run_op(0, 2'b01, 32'h8000_00F0, 5'd4,  32'h0800_000F, 5,  0, 1'b0);
    run_op(0, 2'b11, 32'hDEAD_BEEF, 5'd8,  32'hEFDE_ADBE, 9,  0, 1'b0);
    run_op(0, 2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  0, 1'b1);
    run_op(1, 2'b00, 32'h0000_00FF, 5'd20, 32'h0FF0_0000, 4,  0, 1'b0);
    run_op(1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5,  0, 1'b1);
    run_op(0, 2'b01, 32'hF000_0000, 5'd20, 32'h0000_0F00, 21, 5, 1'b0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    start_v[0] = 1'b1; mode_v[0] = 2'b00; src_v[0] = 32'h0000_0001; shamt_v[0] = 5'd31;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", result_v[0], 32'h0000_0000);
    chk("midrst_ready", W'(ready_v[0]), W'(1));
    chk("midrst_busy", W'(busy_v[0]), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_v[0]) dn++;
    end
    chk("midrst_nodone", W'(dn), W'(0));
    run_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 0, 1'b0);

    // Random traffic on both instances, including starts while busy.
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        start_v[i] = ($urandom_range(0, 3) == 0);
        mode_v[i]  = 2'($urandom_range(0, 3));
        src_v[i]   = $urandom;
        shamt_v[i] = 5'($urandom_range(0, 31));
      end
    end
    start_v = '0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
